ras_controller: RTL and testbench
=================================

// Module: ras_controller
// PURPOSE
//   Return-address-stack controller for the fetch predictor. Holds RAS_ENTRIES PC38 return targets
//   and sequences push (JUMP_L/INDIRECT_L), pop (RET) and pop+push (RET_L) from the fetch redirect.
//   Exports the top-of-stack target for fast ret redirect and the sp/count snapshot for the BCB.
//   Restores sp/count from the BCB on mispredict or restart.
// PARAMETERS
//   RAS_ENTRIES   corep::RAS_ENTRIES (16)   stack depth; power of 2, >= 2
//   INIT_PC38     corep::INIT_PC38 (38'h0)  reset value of every stack entry
// PORTS
//   CLK               in   1    clock
//   nRST              in   1    asynchronous active-low reset
//   req_valid         in   1    fetch issues a stack op this cycle
//   req_push          in   1    push req_push_pc38 (qualified by req_valid)
//   req_pop           in   1    pop top (qualified by req_valid); with req_push = replace top
//   req_push_pc38     in   38   return address to push (PC38_t)
//   restore_valid     in   1    BCB restore (mispredict or restart)
//   restore_ras_index in   4    RAS_idx_t from BCB entry
//   restore_ras_count in   5    RAS_cnt_t from BCB entry
//   restore_top_pc38  in   38   saved top entry; used only with RAS_CTRL_REPAIR_TOP_EN
//   ret_valid         out  1    stack non-empty (count != 0)
//   ret_pc38          out  38   entry[ras_index]; combinational from current state
//   ras_index         out  4    current sp (index of top entry), for BCB save
//   ras_count         out  5    current occupancy 0..RAS_ENTRIES, for BCB save
//   underflow         out  1    registered pulse: pop accepted while count == 0
// BEHAVIOUR
//   Reset (async on nRST low):
//     ras_index = 0; ras_count = 0; all entries = INIT_PC38; underflow = 0
//     -> ret_valid = 0; ret_pc38 = INIT_PC38
//   All outputs reflect the pre-update state.
//     Ops take effect at the next CLK edge; a 1-cycle op-to-visible latency.
//   Priority: restore_valid > req_valid. A request coincident with a restore is dropped entirely.
//   Push only: idx' = idx+1 (mod RAS_ENTRIES); entry[idx'] = req_push_pc38;
//     count' = min(count+1, RAS_ENTRIES).
//     At full, wrap overwrites the oldest entry and count saturates at RAS_ENTRIES.
//   Pop only:
//     count > 0: idx' = idx-1 (mod); count' = count-1
//     count == 0: idx, count unchanged; underflow pulses next cycle
//   Push+pop (RET_L): idx and count unchanged; entry[idx] = req_push_pc38.
//     At count == 0 this acts as push, and underflow is not raised.
//   Restore: idx' = restore_ras_index; count' = restore_ras_count.
//     Entries are untouched unless RAS_CTRL_REPAIR_TOP_EN is defined.
//     restore_ras_count > RAS_ENTRIES is illegal; it is clamped to RAS_ENTRIES.
//   req_valid with neither push nor pop: no-op.
//   underflow is a single-cycle pulse; it is 0 otherwise.
//   Index arithmetic is LOG_RAS_ENTRIES-bit wrap. Count arithmetic is (LOG_RAS_ENTRIES+1)-bit saturating.
// CONFIGURATION
//   RAS_CTRL_REPAIR_TOP_EN defined:
//     On restore, also write entry[restore_ras_index] = restore_top_pc38.
//     This repairs a top entry clobbered by a wrong-path push.
//     BCB_info_t carries a PC38 top field when this is enabled.
//   Undefined: the restore_top_pc38 port exists but is ignored.
//     Only the pointer is restored, and wrong-path pushes can corrupt the restored top.
// STRUCTURE
//   corep: RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t, RAS_cnt_t, PC38_t, INIT_PC38 (existing).
//   corep, new: BCB_info_t gains a top_pc38 field under RAS_CTRL_REPAIR_TOP_EN.
//   No sub-module: a flop array plus a small pointer/count datapath, written with one write port.
//   The single write port suffices: push, replace and repair writes are mutually exclusive per cycle.
// TESTING
//   1. Reset; push A=38'h100, push B=38'h200 -> ras_index=2, ras_count=2, ret_pc38=B.
//      Then pop -> ret_pc38=A, ras_count=1.
//   2. 17 pushes P0..P16 from reset -> ras_count=16, ras_index=1, ret_pc38=P16, entry[1]=P16.
//      Then 16 pops -> ret_valid=0 and last valid ret_pc38=P1.
//   3. Pop at count=0 -> index/count unchanged, underflow=1 for exactly 1 cycle.
//      Push+pop at count=0 -> count=1, no underflow.
//   4. count=3, idx=3, push+pop C=38'h3C0 -> idx=3, count=3, ret_pc38=C.
//   5. Push X concurrent with restore(idx=5, count=4) -> idx=5, count=4, X not written.
//      With RAS_CTRL_REPAIR_TOP_EN, entry[5] = restore_top_pc38.
//   6. Assert nRST mid-stream after 4 pushes -> immediately count=0, ret_valid=0, ret_pc38=INIT_PC38.

Source files
------------

// File: rtl/ras_controller_pkg.sv
// Shared types and constants for the return-address-stack controller.
// BCB_info_t gains top_pc38 when RAS_CTRL_REPAIR_TOP_EN is defined.
package ras_controller_pkg;

    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);

    typedef logic [37:0]                PC38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   RAS_cnt_t;

    localparam PC38_t INIT_PC38 = 38'h0;

    typedef struct packed {
        RAS_idx_t ras_index;
        RAS_cnt_t ras_count;
`ifdef RAS_CTRL_REPAIR_TOP_EN
        PC38_t    top_pc38;
`endif
    } BCB_info_t;

endpackage

// File: rtl/ras_controller.sv
// Return-address stack: push/pop/replace from fetch, pointer restore from the BCB.
// Optional RAS_CTRL_REPAIR_TOP_EN also rewrites the restored top entry.
module ras_controller
    import ras_controller_pkg::*;
#(
    parameter int    RAS_ENTRIES = ras_controller_pkg::RAS_ENTRIES,
    parameter PC38_t INIT_PC38   = ras_controller_pkg::INIT_PC38,
    localparam int   LOG         = $clog2(RAS_ENTRIES)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          req_valid,
    input  logic          req_push,
    input  logic          req_pop,
    input  logic [37:0]   req_push_pc38,
    input  logic          restore_valid,
    input  logic [LOG-1:0] restore_ras_index,
    input  logic [LOG:0]  restore_ras_count,
    input  logic [37:0]   restore_top_pc38,
    output logic          ret_valid,
    output logic [37:0]   ret_pc38,
    output logic [LOG-1:0] ras_index,
    output logic [LOG:0]  ras_count,
    output logic          underflow
);

    localparam logic [LOG:0] CNT_MAX = (LOG+1)'(RAS_ENTRIES);

    PC38_t          entries [RAS_ENTRIES];
    logic [LOG-1:0] idx, idx_nxt;
    logic [LOG:0]   cnt, cnt_nxt;
    logic           uf, uf_nxt;

    // Single write port: push, replace and repair never coincide in one cycle.
    logic           wr_en;
    logic [LOG-1:0] wr_idx;
    PC38_t          wr_data;

    always_comb begin
        idx_nxt = idx;
        cnt_nxt = cnt;
        uf_nxt  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_data = req_push_pc38;
        if (restore_valid) begin
            idx_nxt = restore_ras_index;
            cnt_nxt = (restore_ras_count > CNT_MAX) ? CNT_MAX : restore_ras_count;
`ifdef RAS_CTRL_REPAIR_TOP_EN
            wr_en   = 1'b1;
            wr_idx  = restore_ras_index;
            wr_data = restore_top_pc38;
`endif
        end else if (req_valid) begin
            if (req_push && req_pop && cnt != '0) begin
                wr_en = 1'b1;
            end else if (req_push) begin
                // Covers push+pop on an empty stack, which behaves as a plain push.
                idx_nxt = idx + 1'b1;
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                wr_en   = 1'b1;
                wr_idx  = idx + 1'b1;
            end else if (req_pop) begin
                if (cnt != '0) begin
                    idx_nxt = idx - 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    uf_nxt = 1'b1;
                end
            end
        end
    end

`ifndef RAS_CTRL_REPAIR_TOP_EN
    logic unused_top;
    assign unused_top = ^restore_top_pc38;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx <= '0;
            cnt <= '0;
            uf  <= 1'b0;
            for (int i = 0; i < RAS_ENTRIES; i++) entries[i] <= INIT_PC38;
        end else begin
            idx <= idx_nxt;
            cnt <= cnt_nxt;
            uf  <= uf_nxt;
            if (wr_en) entries[wr_idx] <= wr_data;
        end
    end

    assign ret_valid = (cnt != '0);
    assign ret_pc38  = entries[idx];
    assign ras_index = idx;
    assign ras_count = cnt;
    assign underflow = uf;

endmodule

// File: tb/tb_ras_controller.sv
// Self-checking bench for ras_controller: directed scenarios plus randomized ops
// against a queue-free array model of the return-address stack.
module tb_ras_controller;
    localparam int N = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req_valid = 0, req_push = 0, req_pop = 0;
    logic [37:0] req_push_pc38 = '0;
    logic        restore_valid = 0;
    logic [3:0]  restore_ras_index = '0;
    logic [4:0]  restore_ras_count = '0;
    logic [37:0] restore_top_pc38 = '0;
    logic        ret_valid;
    logic [37:0] ret_pc38;
    logic [3:0]  ras_index;
    logic [4:0]  ras_count;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: plain array + integer pointer/occupancy.
    logic [37:0] m_ent [N];
    int          m_idx, m_cnt;
    bit          m_uf;

    always #5 CLK = ~CLK;

    ras_controller dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_push(req_push), .req_pop(req_pop),
        .req_push_pc38(req_push_pc38),
        .restore_valid(restore_valid), .restore_ras_index(restore_ras_index),
        .restore_ras_count(restore_ras_count), .restore_top_pc38(restore_top_pc38),
        .ret_valid(ret_valid), .ret_pc38(ret_pc38), .ras_index(ras_index),
        .ras_count(ras_count), .underflow(underflow)
    );

    function automatic logic [48:0] model_vec();
        return {m_cnt != 0, m_ent[m_idx], 4'(m_idx), 5'(m_cnt), m_uf};
    endfunction

    function automatic logic [48:0] dut_vec();
        return {ret_valid, ret_pc38, ras_index, ras_count, underflow};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ent[i] = 38'h0;
        m_idx = 0; m_cnt = 0; m_uf = 0;
    endtask

    task automatic model_step(bit v, bit pu, bit po, logic [37:0] pc,
                              bit rv, int ri, int rc, logic [37:0] rt);
        m_uf = 0;
        if (rv) begin
            m_idx = ri;
            m_cnt = (rc > N) ? N : rc;
`ifdef RAS_CTRL_REPAIR_TOP_EN
            m_ent[ri] = rt;
`endif
        end else if (v) begin
            if (pu && po && m_cnt > 0) begin
                m_ent[m_idx] = pc;
            end else if (pu) begin
                m_idx = (m_idx + 1) % N;
                m_ent[m_idx] = pc;
                m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
            end else if (po) begin
                if (m_cnt > 0) begin
                    m_idx = (m_idx + N - 1) % N;
                    m_cnt = m_cnt - 1;
                end else begin
                    m_uf = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample at the following negedge.
    task automatic cycle(bit v, bit pu, bit po, logic [37:0] pc,
                         bit rv = 0, int ri = 0, int rc = 0, logic [37:0] rt = '0);
        req_valid = v; req_push = pu; req_pop = po; req_push_pc38 = pc;
        restore_valid = rv; restore_ras_index = 4'(ri);
        restore_ras_count = 5'(rc); restore_top_pc38 = rt;
        @(posedge CLK);
        model_step(v, pu, po, pc, rv, ri, rc, rt);
        #1;
        req_valid = 0; req_push = 0; req_pop = 0; restore_valid = 0;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== {1'b0, 38'h0, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(), {1'b0, 38'h0, 4'd0, 5'd0, 1'b0});
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        cycle(1, 1, 0, 38'h100);
        cycle(1, 1, 0, 38'h200);
        checks++;
        if ({ras_index, ras_count, ret_pc38} !== {4'd2, 5'd2, 38'h200}) begin
            errors++;
            $display("FAIL push2 got idx=%0d cnt=%0d pc=%h want idx=2 cnt=2 pc=200", ras_index, ras_count, ret_pc38);
        end
        cycle(1, 0, 1, '0);
        checks++;
        if ({ret_pc38, ras_count} !== {38'h100, 5'd1}) begin
            errors++;
            $display("FAIL pop1 got pc=%h cnt=%0d want pc=100 cnt=1", ret_pc38, ras_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k <= 16; k++) cycle(1, 1, 0, 38'h1000 + 38'(k));
        checks++;
        if ({ras_count, ras_index, ret_pc38} !== {5'd16, 4'd1, 38'h1010}) begin
            errors++;
            $display("FAIL wrap_full got cnt=%0d idx=%0d pc=%h want cnt=16 idx=1 pc=1010", ras_count, ras_index, ret_pc38);
        end
        for (int k = 0; k < 15; k++) cycle(1, 0, 1, '0);
        checks++;
        if ({ret_valid, ras_count, ret_pc38} !== {1'b1, 5'd1, 38'h1001}) begin
            errors++;
            $display("FAIL wrap_last got v=%0b cnt=%0d pc=%h want v=1 cnt=1 pc=1001", ret_valid, ras_count, ret_pc38);
        end
        cycle(1, 0, 1, '0);
        checks++;
        if (ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty got ret_valid=%0b want 0", ret_valid);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1, 0, 1, '0);
        checks++;
        if ({underflow, ras_index, ras_count} !== {1'b1, 4'd0, 5'd0}) begin
            errors++;
            $display("FAIL underflow_pulse got uf=%0b idx=%0d cnt=%0d want uf=1 idx=0 cnt=0", underflow, ras_index, ras_count);
        end
        cycle(0, 0, 0, '0);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got %0b want 0", underflow);
        end
        cycle(1, 1, 1, 38'h777);
        checks++;
        if ({underflow, ras_count, ret_pc38} !== {1'b0, 5'd1, 38'h777}) begin
            errors++;
            $display("FAIL retl_empty got uf=%0b cnt=%0d pc=%h want uf=0 cnt=1 pc=777", underflow, ras_count, ret_pc38);
        end
    endtask

    task automatic test_replace();
        do_reset();
        for (int k = 1; k <= 3; k++) cycle(1, 1, 0, 38'h300 + 38'(k));
        cycle(1, 1, 1, 38'h3C0);
        checks++;
        if ({ras_index, ras_count, ret_pc38, underflow} !== {4'd3, 5'd3, 38'h3C0, 1'b0}) begin
            errors++;
            $display("FAIL replace got idx=%0d cnt=%0d pc=%h want idx=3 cnt=3 pc=3c0", ras_index, ras_count, ret_pc38);
        end
        cycle(1, 0, 1, '0);
        checks++;
        if (ret_pc38 !== 38'h302) begin
            errors++;
            $display("FAIL replace_below got pc=%h want 302", ret_pc38);
        end
    endtask

    task automatic test_restore();
        logic [37:0] want;
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1, 1, 0, 38'h500 + 38'(k));
        cycle(1, 1, 0, 38'hABC, 1, 5, 4, 38'h5E5);
`ifdef RAS_CTRL_REPAIR_TOP_EN
        want = 38'h5E5;
`else
        want = 38'h504;
`endif
        checks++;
        if ({ras_index, ras_count, ret_pc38} !== {4'd5, 5'd4, want}) begin
            errors++;
            $display("FAIL restore got idx=%0d cnt=%0d pc=%h want idx=5 cnt=4 pc=%h", ras_index, ras_count, ret_pc38, want);
        end
        cycle(1, 1, 0, 38'hD00);
        checks++;
        if ({ras_index, ret_pc38} !== {4'd6, 38'hD00}) begin
            errors++;
            $display("FAIL restore_then_push got idx=%0d pc=%h want idx=6 pc=d00", ras_index, ret_pc38);
        end
        cycle(0, 0, 0, '0, 1, 9, 31, 38'h0);
        checks++;
        if ({ras_index, ras_count} !== {4'd9, 5'd16}) begin
            errors++;
            $display("FAIL restore_clamp got idx=%0d cnt=%0d want idx=9 cnt=16", ras_index, ras_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit rv, v, pu, po;
            rv = ($urandom_range(0, 9) == 0);
            v  = ($urandom_range(0, 3) != 0);
            pu = $urandom_range(0, 1);
            po = $urandom_range(0, 1);
            cycle(v, pu, po, {6'h0, 32'($urandom)}, rv,
                  $urandom_range(0, 15), $urandom_range(0, 20), {6'h3, 32'($urandom)});
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d] got={v,pc,idx,cnt,uf}=%h want=%h", n, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 1, 0, 38'h900 + 38'(k));
        #2 nRST = 0;
        #1;
        checks++;
        if ({ras_count, ret_valid, ret_pc38, ras_index} !== {5'd0, 1'b0, 38'h0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d v=%0b pc=%h idx=%0d want all zero", ras_count, ret_valid, ret_pc38, ras_index);
        end
        model_reset();
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        cycle(1, 1, 0, 38'hF0);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL post_reset_push got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_wrap();
        test_underflow();
        test_replace();
        test_restore();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
